// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC and the icache request, and fills the IF/ID latch.
// Redirects that arrive while IF is stalled are parked, then applied when the stall releases.
module pc_fetch_unit #(
  parameter int                 WORD_W  = 32,
  parameter logic [WORD_W-1:0]  PC_INIT = '0
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              ifW,
  input  logic              ifRST,
  input  logic              brnch_valid,
  input  logic [WORD_W-1:0] brnch_target,
  input  logic              jr_valid,
  input  logic [WORD_W-1:0] jr_target,
  input  logic              jmp_valid,
  input  logic [WORD_W-1:0] jmp_target,
  input  logic              halt,
  output logic [WORD_W-1:0] if_instr,
  output logic [WORD_W-1:0] if_npc,
  output logic              if_valid,
  output logic              halted
);

  typedef enum logic [1:0] {
    RUN,
    REDIR_PEND,
    HALTED
  } state_t;

  // Class encodes redirect priority numerically: an older instruction gets a larger value.
  typedef enum logic [1:0] {
    CLS_NONE,
    CLS_JMP,
    CLS_JR,
    CLS_BR
  } redir_cls_t;

  localparam logic [WORD_W-1:0] PC_STEP = WORD_W'(4);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic [WORD_W-1:0] npc_q, npc_d;
  logic              valid_q, valid_d;
  logic [WORD_W-1:0] pendTgt_q, pendTgt_d;
  redir_cls_t        pendCls_q, pendCls_d;

  redir_cls_t        newCls;
  logic [WORD_W-1:0] newTgt;
  logic              redir;
  logic [WORD_W-1:0] pcPlus4;

  always_comb begin
    newCls = CLS_NONE;
    newTgt = '0;
    if (brnch_valid) begin
      newCls = CLS_BR;
      newTgt = brnch_target;
    end else if (jr_valid) begin
      newCls = CLS_JR;
      newTgt = jr_target;
    end else if (jmp_valid) begin
      newCls = CLS_JMP;
      newTgt = jmp_target;
    end
  end

  assign redir   = (newCls != CLS_NONE);
  assign pcPlus4 = pc_q + PC_STEP;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    npc_d     = npc_q;
    valid_d   = valid_q;
    pendTgt_d = pendTgt_q;
    pendCls_d = pendCls_q;

    unique case (state_q)
      RUN: begin
        if (halt) begin
          state_d = HALTED;
          instr_d = '0;
          npc_d   = '0;
          valid_d = 1'b0;
        end else if (redir && ifW) begin
          pc_d    = newTgt;
          instr_d = '0;
          npc_d   = '0;
          valid_d = 1'b0;
        end else if (redir) begin
          pendTgt_d = newTgt;
          pendCls_d = newCls;
          state_d   = REDIR_PEND;
        end else if (ifW && ifRST) begin
          instr_d = '0;
          npc_d   = '0;
          valid_d = 1'b0;
          if (ihit) pc_d = pcPlus4;
        end else if (ifW && ihit) begin
          instr_d = imemload;
          npc_d   = pcPlus4;
          valid_d = 1'b1;
          pc_d    = pcPlus4;
        end else if (ifW) begin
          instr_d = '0;
          npc_d   = '0;
          valid_d = 1'b0;
        end
      end

      REDIR_PEND: begin
        // A parked redirect always wins over halt: the halting instruction is on the squashed path.
        if (redir && (newCls > pendCls_q)) begin
          pendTgt_d = newTgt;
          pendCls_d = newCls;
        end
        if (ifW) begin
          pc_d      = pendTgt_d;
          instr_d   = '0;
          npc_d     = '0;
          valid_d   = 1'b0;
          pendCls_d = CLS_NONE;
          state_d   = RUN;
        end
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= RUN;
      pc_q      <= PC_INIT;
      instr_q   <= '0;
      npc_q     <= '0;
      valid_q   <= 1'b0;
      pendTgt_q <= '0;
      pendCls_q <= CLS_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      npc_q     <= npc_d;
      valid_q   <= valid_d;
      pendTgt_q <= pendTgt_d;
      pendCls_q <= pendCls_d;
    end
  end

  assign imemaddr = pc_q;
  assign imemREN  = (state_q == RUN);
  assign halted   = (state_q == HALTED);
  assign if_instr = instr_q;
  assign if_npc   = npc_q;
  assign if_valid = valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed walk through the fetch scenarios, then random traffic
// compared every cycle against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] imemload = '0;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ifW = 1'b0;
  logic        ifRST = 1'b0;
  logic        brnch_valid = 1'b0;
  logic [31:0] brnch_target = '0;
  logic        jr_valid = 1'b0;
  logic [31:0] jr_target = '0;
  logic        jmp_valid = 1'b0;
  logic [31:0] jmp_target = '0;
  logic        halt = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_npc;
  logic        if_valid;
  logic        halted;

  int checks = 0;
  int passes = 0;

  pc_fetch_unit #(.WORD_W(32), .PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .ifW(ifW), .ifRST(ifRST),
    .brnch_valid(brnch_valid), .brnch_target(brnch_target),
    .jr_valid(jr_valid), .jr_target(jr_target),
    .jmp_valid(jmp_valid), .jmp_target(jmp_target),
    .halt(halt), .if_instr(if_instr), .if_npc(if_npc),
    .if_valid(if_valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  // Reference model: fetch mode plus the IF/ID contents and the oldest parked redirect.
  // Redirect sources are listed oldest first, so a lower index always wins.
  bit          mHalted, mPending;
  logic [31:0] mPc, mInstr, mNpc;
  bit          mValid;
  int          mPendAge;
  logic [31:0] mPendTgt;

  task automatic modelReset();
    mHalted = 0; mPending = 0; mPc = 32'h0;
    mInstr = 0; mNpc = 0; mValid = 0; mPendAge = 99; mPendTgt = 0;
  endtask

  task automatic modelBubble();
    mInstr = 0; mNpc = 0; mValid = 0;
  endtask

  task automatic modelStep();
    bit          reqV[3];
    logic [31:0] reqT[3];
    int          win;
    reqV[0] = brnch_valid; reqT[0] = brnch_target;
    reqV[1] = jr_valid;    reqT[1] = jr_target;
    reqV[2] = jmp_valid;   reqT[2] = jmp_target;
    win = -1;
    for (int i = 2; i >= 0; i--) if (reqV[i]) win = i;
    if (mHalted) return;
    if (mPending) begin
      if (win >= 0 && win < mPendAge) begin
        mPendAge = win; mPendTgt = reqT[win];
      end
      if (ifW) begin
        mPc = mPendTgt; modelBubble(); mPending = 0; mPendAge = 99;
      end
      return;
    end
    if (halt) begin
      mHalted = 1; modelBubble();
    end else if (win >= 0) begin
      if (ifW) begin
        mPc = reqT[win]; modelBubble();
      end else begin
        mPending = 1; mPendAge = win; mPendTgt = reqT[win];
      end
    end else if (ifW) begin
      if (ifRST || !ihit) modelBubble();
      else begin
        mInstr = imemload; mNpc = mPc + 32'd4; mValid = 1;
      end
      if (ihit) mPc = mPc + 32'd4;
    end
  endtask

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) modelReset();
    else modelStep();
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Every negative edge the outputs are compared with the model.
  always @(negedge CLK) begin
    checkOutput("model imemaddr", imemaddr, mPc);
    checkOutput("model imemREN", {31'b0, imemREN}, {31'b0, !mHalted && !mPending});
    checkOutput("model halted", {31'b0, halted}, {31'b0, mHalted});
    checkOutput("model if_instr", if_instr, mInstr);
    checkOutput("model if_npc", if_npc, mNpc);
    checkOutput("model if_valid", {31'b0, if_valid}, {31'b0, mValid});
  end

  task automatic idle();
    ihit = 0; imemload = 0; ifW = 0; ifRST = 0; halt = 0;
    brnch_valid = 0; jr_valid = 0; jmp_valid = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    #1;
  endtask

  task automatic applyStimulus();
    idle();
    ifW   = ($urandom_range(0, 3) != 0);
    ihit  = ($urandom_range(0, 2) != 0);
    ifRST = ($urandom_range(0, 7) == 0);
    halt  = ($urandom_range(0, 99) == 0);
    imemload = $urandom;
    brnch_valid = ($urandom_range(0, 9) == 0); brnch_target = $urandom;
    jr_valid    = ($urandom_range(0, 9) == 0); jr_target    = $urandom;
    jmp_valid   = ($urandom_range(0, 9) == 0); jmp_target   = $urandom & 32'hFFFF_FFFC;
  endtask

  initial begin
    int haltCycles;
    idle();
    nRST = 0;
    #12;
    @(negedge CLK); #1;
    nRST = 1;
    checkOutput("reset imemaddr", imemaddr, 32'h0);
    checkOutput("reset if_valid", {31'b0, if_valid}, 32'h0);

    ifW = 1; ihit = 1; imemload = 32'hAAAA_0001; tick();
    checkOutput("fetch A instr", if_instr, 32'hAAAA_0001);
    checkOutput("fetch A npc", if_npc, 32'h4);
    checkOutput("fetch A addr", imemaddr, 32'h4);
    imemload = 32'hBBBB_0002; tick();
    checkOutput("fetch B instr", if_instr, 32'hBBBB_0002);
    checkOutput("fetch B addr", imemaddr, 32'h8);
    imemload = 32'hCCCC_0003; tick();
    checkOutput("fetch C npc", if_npc, 32'hC);
    checkOutput("fetch C valid", {31'b0, if_valid}, 32'h1);
    nRST = 0; #1;
    checkOutput("async rst addr", imemaddr, 32'h0);
    checkOutput("async rst instr", if_instr, 32'h0);
    checkOutput("async rst npc", if_npc, 32'h0);
    checkOutput("async rst valid", {31'b0, if_valid}, 32'h0);
    idle(); tick(); nRST = 1;

    ifW = 1; jmp_valid = 1; jmp_target = 32'h40; tick();
    idle(); ifW = 1; ihit = 1; imemload = 32'hEEEE_0004; tick();
    checkOutput("pre-branch valid", {31'b0, if_valid}, 32'h1);
    idle(); ifW = 1; brnch_valid = 1; brnch_target = 32'h100;
    jmp_valid = 1; jmp_target = 32'h200; tick();
    checkOutput("branch beats jump", imemaddr, 32'h100);
    checkOutput("redirect bubble", {31'b0, if_valid}, 32'h0);

    idle(); jmp_valid = 1; jmp_target = 32'h80; tick();
    checkOutput("pend imemREN", {31'b0, imemREN}, 32'h0);
    checkOutput("pend pc held", imemaddr, 32'h100);
    idle(); brnch_valid = 1; brnch_target = 32'h300; tick();
    idle(); jmp_valid = 1; jmp_target = 32'h900; tick();
    idle(); ifW = 1; tick();
    checkOutput("pend replaced", imemaddr, 32'h300);
    checkOutput("pend release REN", {31'b0, imemREN}, 32'h1);

    idle(); ihit = 1; imemload = 32'hDDDD_0005; tick(); tick();
    checkOutput("stall pc", imemaddr, 32'h300);
    checkOutput("stall instr", if_instr, 32'h0);
    ifW = 1; tick();
    checkOutput("refetch instr", if_instr, 32'hDDDD_0005);
    checkOutput("refetch addr", imemaddr, 32'h304);

    idle(); ifW = 1; jmp_valid = 1; jmp_target = 32'h20; tick();
    idle(); halt = 1; ifW = 1; ihit = 1; tick();
    checkOutput("halted flag", {31'b0, halted}, 32'h1);
    checkOutput("halted REN", {31'b0, imemREN}, 32'h0);
    idle(); ifW = 1; ihit = 1; jmp_valid = 1; jmp_target = 32'h500; tick();
    idle(); brnch_valid = 1; brnch_target = 32'h600; tick();
    checkOutput("halted pc", imemaddr, 32'h20);
    nRST = 0; #1;
    checkOutput("halt reset flag", {31'b0, halted}, 32'h0);
    checkOutput("halt reset addr", imemaddr, 32'h0);
    idle(); tick(); nRST = 1;

    ifW = 1; jmp_valid = 1; jmp_target = 32'hFFFF_FFFC; tick();
    idle(); ifW = 1; ihit = 1; imemload = 32'hF0F0_0006; tick();
    checkOutput("wrap npc", if_npc, 32'h0);
    checkOutput("wrap addr", imemaddr, 32'h0);
    ifRST = 1; tick();
    checkOutput("flush valid", {31'b0, if_valid}, 32'h0);
    checkOutput("flush pc advance", imemaddr, 32'h4);

    haltCycles = 0;
    for (int n = 0; n < 3000; n++) begin
      applyStimulus();
      if (halted) haltCycles++;
      if (haltCycles > 6 || $urandom_range(0, 499) == 0) begin
        haltCycles = 0;
        nRST = 0; #2; nRST = 1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch front end of the five-stage pipeline.
- Owns the PC register and the icache request (imemREN/imemaddr), and produces the IF/ID latch contents (instruction, PC+4, valid).
- Consumes the hazard unit's ifW (IF write enable) and ifRST (IF flush), plus redirect requests from decode (jump, JR) and execute (taken branch).
- Captures redirects that arrive during a stall and applies them when the stall releases; parks in a halted state on HALT.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, instruction/address width (PC increment fixed at 4)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
ihit  in  1  icache has valid data for imemaddr this cycle
imemload  in  WORD_W  instruction word from icache
imemREN  out  1  icache read enable
imemaddr  out  WORD_W  icache read address (= PC)
ifW  in  1  hazard unit: IF/ID write / PC advance enable
ifRST  in  1  hazard unit: flush IF/ID to bubble
brnch_valid  in  1  taken branch resolved in EX
brnch_target  in  WORD_W  branch target
jr_valid  in  1  JR in ID
jr_target  in  WORD_W  register target
jmp_valid  in  1  J/JAL in ID
jmp_target  in  WORD_W  jump target
halt  in  1  HALT decoded; stop fetching
if_instr  out  WORD_W  IF/ID instruction (0 = nop bubble)
if_npc  out  WORD_W  IF/ID PC+4 of if_instr
if_valid  out  1  IF/ID holds a real instruction
halted  out  1  fetch parked in HALTED

Behaviour:
- Reset (nRST low, async): PC=PC_INIT, if_instr=0, if_npc=0, if_valid=0, state=RUN, pending regs cleared, halted=0. Takes effect immediately, including mid-redirect or while halted.
- States: RUN, REDIR_PEND, HALTED.
- Outputs by state:
  - imemaddr=PC at all times.
  - imemREN=1 in RUN, 0 in REDIR_PEND and HALTED.
  - halted=1 only in HALTED.
- Redirect priority (oldest instruction wins): brnch > jr > jmp. "redir" = any valid; "tgt" = target of the winner.
- RUN, per rising edge, first matching rule applies:
  1. halt=1: state->HALTED; PC held; IF/ID <- bubble (instr=0, valid=0, npc=0).
  2. redir and ifW=1: PC<=tgt; IF/ID <- bubble; stay RUN.
  3. redir and ifW=0: pend_tgt<=tgt, pend_cls<=winner class; PC held; IF/ID held; state->REDIR_PEND.
  4. ifW=1 and ifRST=1: IF/ID <- bubble. PC<=PC+4 if ihit, else held.
  5. ifW=1, ihit=1: if_instr<=imemload, if_npc<=PC+4, if_valid<=1, PC<=PC+4.
  6. ifW=1, ihit=0: IF/ID <- bubble; PC held.
  7. ifW=0: PC and IF/ID held. An ihit in this cycle is discarded and the word is refetched later.
- REDIR_PEND:
  - New redirect of strictly higher class replaces pend_tgt/pend_cls; equal or lower class is ignored.
  - halt=1 is ignored; the pending redirect squashes it.
  - ifW=0: hold everything.
  - ifW=1: PC<=pend_tgt (or the replacing target that same cycle); IF/ID <- bubble; state->RUN.
- HALTED: PC and IF/ID held as bubble; all inputs ignored; exit only via nRST.
- Arithmetic: PC+4 is modulo 2^WORD_W; 32'hFFFF_FFFC wraps to 0, with no flag. Targets are used as given, with no alignment check.
- Simultaneous ifRST and redir with ifW=1: rule 2 applies (same bubble result, PC takes tgt).
- Latency: instruction at PC appears on if_instr one edge after the cycle with ifW=1 and ihit=1. A redirect takes effect on imemaddr one edge after acceptance.

Test Plan:
1. Reset with PC_INIT=0, then ihit=1, ifW=1 for 3 cycles with imemload=A,B,C -> imemaddr 0,4,8,C. if_instr A,B,C; if_npc 4,8,C; if_valid=1. Assert nRST low mid-run -> all outputs 0 and imemaddr=0 immediately, without waiting for an edge.
2. PC=0x40, brnch_valid (0x100) and jmp_valid (0x200) in the same cycle with ifW=1 -> next imemaddr=0x100, IF/ID bubble.
3. ifW=0; jmp_valid (0x80) for 1 cycle -> REDIR_PEND, imemREN=0, PC held. Next cycle brnch_valid (0x300) -> replaces pending. ifW=1 two cycles later -> imemaddr=0x300, RUN, bubble.
4. ifW=0 with ihit=1, imemload=D for 2 cycles -> PC and if_instr unchanged. Then ifW=1, ihit=1 -> if_instr=D, PC+4.
5. halt=1 at PC=0x20 -> halted=1, imemREN=0, imemaddr stays 0x20. Later redir/ifW toggles have no effect. nRST -> RUN at PC_INIT.
6. PC=32'hFFFF_FFFC, ihit=1, ifW=1 -> if_npc=0, next imemaddr=0. ifRST=1 with ifW=1, ihit=1 -> if_valid=0, PC advances.
